// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: reset-request FSM encoding
// and bit positions within the sticky reset-cause record.
package sys_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ASSERT   = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_WAIT_REL = 3'd3,
    ST_HOLDOFF  = 3'd4
  } rst_state_t;

  localparam int RI_SYSREQ = 0;
  localparam int RI_LOCKUP = 1;
  localparam int RI_WDOG   = 2;
  localparam int RI_EXT    = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset and a
// selectable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sys_reset_req_gen.sv
// Merges CPU, lockup, watchdog and external reset sources into one stretched
// RSTREQ pulse, tracks the controller's HRESETn response and keeps a sticky cause record.
module sys_reset_req_gen
  import sys_ctrl_pkg::*;
#(
  parameter int MIN_PULSE   = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int HOLDOFF     = 8,
  parameter int CNT_W       = 8
) (
  input  logic       FCLK,
  input  logic       PORESET,
  input  logic       SYSRESETREQ,
  input  logic       LOCKUP,
  input  logic       LOCKUP_RST_EN,
  input  logic       WDOG_RST,
  input  logic       EXT_RST_REQ,
  input  logic       HRESETn_MON,
  input  logic       RST_INFO_CLR,
  output logic       RSTREQ,
  output logic [3:0] RST_INFO,
  output logic       RST_BUSY,
  output logic       RST_TIMEOUT,
  output logic [2:0] dbg_state
);

  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(MIN_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_ACK   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLDOFF - 1);

  rst_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       src, info_n;
  logic             any_src, hrst_s, rec, set_to, to_n, req_n;

  // Sync flops reset to 0 so the system is treated as in reset until proven otherwise.
  sync_2ff #(.RESET_VAL(1'b0)) u_hrst_sync (
    .clk (FCLK),
    .rst (PORESET),
    .d   (HRESETn_MON),
    .q   (hrst_s)
  );

  always_comb begin
    src            = '0;
    src[RI_SYSREQ] = SYSRESETREQ;
    src[RI_LOCKUP] = LOCKUP & LOCKUP_RST_EN;
    src[RI_WDOG]   = WDOG_RST;
    src[RI_EXT]    = EXT_RST_REQ;
    any_src        = |src;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rec     = 1'b0;
    set_to  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_src && hrst_s) begin
          state_n = ST_ASSERT;
          cnt_n   = LD_PULSE;
          rec     = 1'b1;
        end
      end
      ST_ASSERT: begin
        rec = 1'b1;
        if (cnt == '0) begin
          if (!hrst_s) begin
            state_n = ST_WAIT_REL;
          end else begin
            state_n = ST_WAIT_ACK;
            cnt_n   = LD_ACK;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_WAIT_ACK: begin
        if (!hrst_s) begin
          state_n = ST_WAIT_REL;
        end else if (cnt == '0) begin
          // Abandoned request: not retried, just flagged.
          set_to  = 1'b1;
          state_n = ST_HOLDOFF;
          cnt_n   = LD_HOLD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_WAIT_REL: begin
        if (hrst_s) begin
          state_n = ST_HOLDOFF;
          cnt_n   = LD_HOLD;
        end
      end
      ST_HOLDOFF: begin
        if (cnt == '0) state_n = ST_IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    // A cause recorded in the clear cycle survives; a timeout set in the clear cycle wins.
    info_n = (RST_INFO_CLR ? 4'b0000 : RST_INFO) | (rec ? src : 4'b0000);
    to_n   = set_to | (RST_TIMEOUT & ~RST_INFO_CLR);
    req_n  = (state_n == ST_ASSERT) || (state_n == ST_WAIT_ACK);
  end

  always_ff @(posedge FCLK or posedge PORESET) begin
    if (PORESET) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      RSTREQ      <= 1'b0;
      RST_INFO    <= 4'b0000;
      RST_BUSY    <= 1'b0;
      RST_TIMEOUT <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      RSTREQ      <= req_n;
      RST_INFO    <= info_n;
      RST_BUSY    <= (state_n != ST_IDLE);
      RST_TIMEOUT <= to_n;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_sys_reset_req_gen.sv
// Self-checking bench for sys_reset_req_gen: scenario tasks with a queue of
// expected results pushed at stimulus time and popped when the DUT responds.
module tb_sys_reset_req_gen;
  import sys_ctrl_pkg::*;

  localparam int MIN_PULSE   = 4;
  localparam int ACK_TIMEOUT = 64;
  localparam int HOLDOFF     = 8;

  logic       FCLK = 1'b0;
  logic       PORESET, SYSRESETREQ, LOCKUP, LOCKUP_RST_EN, WDOG_RST;
  logic       EXT_RST_REQ, HRESETn_MON, RST_INFO_CLR;
  logic       RSTREQ, RST_BUSY, RST_TIMEOUT;
  logic [3:0] RST_INFO;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  sys_reset_req_gen #(
    .MIN_PULSE(MIN_PULSE), .ACK_TIMEOUT(ACK_TIMEOUT), .HOLDOFF(HOLDOFF), .CNT_W(8)
  ) dut (
    .FCLK(FCLK), .PORESET(PORESET), .SYSRESETREQ(SYSRESETREQ), .LOCKUP(LOCKUP),
    .LOCKUP_RST_EN(LOCKUP_RST_EN), .WDOG_RST(WDOG_RST), .EXT_RST_REQ(EXT_RST_REQ),
    .HRESETn_MON(HRESETn_MON), .RST_INFO_CLR(RST_INFO_CLR), .RSTREQ(RSTREQ),
    .RST_INFO(RST_INFO), .RST_BUSY(RST_BUSY), .RST_TIMEOUT(RST_TIMEOUT),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 FCLK = ~FCLK;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge FCLK);
  endtask

  task automatic clear_info();
    RST_INFO_CLR = 1'b1;
    tick();
    RST_INFO_CLR = 1'b0;
  endtask

  // Counts further cycles RSTREQ stays high (bounded); len starts at the caller's count.
  task automatic count_high(inout int len, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (RSTREQ !== 1'b1) begin ok = 1'b1; break; end
      len++;
    end
  endtask

  // Counts cycles RST_BUSY stays high (bounded).
  task automatic count_busy(output int len, output bit ok);
    ok = 1'b0;
    len = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (RST_BUSY !== 1'b1) begin ok = 1'b1; break; end
      len++;
    end
  endtask

  // Controller response: assert HRESETn until RSTREQ drops, hold, then release.
  task automatic ack_and_release(output int busy_len, output bit ok);
    bit ok_h;
    int dummy;
    dummy = 0;
    HRESETn_MON = 1'b0;
    count_high(dummy, ok_h);
    repeat (5) tick();
    HRESETn_MON = 1'b1;
    count_busy(busy_len, ok);
    ok = ok & ok_h;
  endtask

  task automatic test_reset();
    PORESET = 1'b1; SYSRESETREQ = 1'b0; LOCKUP = 1'b0; LOCKUP_RST_EN = 1'b0;
    WDOG_RST = 1'b0; EXT_RST_REQ = 1'b0; HRESETn_MON = 1'b1; RST_INFO_CLR = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (RSTREQ !== 1'b0) begin n_fail++; $display("FAIL reset_rstreq got=%b exp=0", RSTREQ); end
    n_checks++;
    if (RST_INFO !== 4'b0000) begin n_fail++; $display("FAIL reset_info got=%b exp=0000", RST_INFO); end
    n_checks++;
    if (RST_BUSY !== 1'b0 || RST_TIMEOUT !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags busy=%b timeout=%b exp=0,0", RST_BUSY, RST_TIMEOUT);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    PORESET = 1'b0;
    repeat (4) tick();
  endtask

  // hold_cycle: high-cycle (1-based) during which the controller pulls HRESETn low.
  task automatic test_sysreq(input int hold_cycle, input string tag);
    int len, blen;
    bit ok;
    clear_info();
    exp_q.push_back(32'(MIN_PULSE > hold_cycle + 2 ? MIN_PULSE : hold_cycle + 2));
    exp_q.push_back(32'(HOLDOFF + 2));
    exp_q.push_back(32'b0001);
    SYSRESETREQ = 1'b1;
    tick();
    SYSRESETREQ = 1'b0;
    n_checks++;
    if (RSTREQ !== 1'b1) begin n_fail++; $display("FAIL %s_rise got=%b exp=1", tag, RSTREQ); end
    len = 1;
    for (int c = 2; c <= hold_cycle; c++) begin
      tick();
      if (RSTREQ === 1'b1) len++;
    end
    HRESETn_MON = 1'b0;
    count_high(len, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || len !== int'(exp)) begin n_fail++; $display("FAIL %s_pulse_len got=%0d exp=%0d", tag, len, exp); end
    repeat (6) tick();
    HRESETn_MON = 1'b1;
    count_busy(blen, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || blen !== int'(exp)) begin n_fail++; $display("FAIL %s_busy_len got=%0d exp=%0d", tag, blen, exp); end
    exp = exp_q.pop_front();
    n_checks++;
    if (RST_INFO !== exp[3:0]) begin n_fail++; $display("FAIL %s_info got=%b exp=%b", tag, RST_INFO, exp[3:0]); end
  endtask

  task automatic test_lockup_enable();
    int blen;
    bit ok, seen;
    clear_info();
    seen = 1'b0;
    LOCKUP = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (RSTREQ !== 1'b0 || RST_INFO !== 4'b0000) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL lockup_masked got=activity exp=none"); end
    LOCKUP_RST_EN = 1'b1;
    tick();
    LOCKUP = 1'b0;
    n_checks++;
    if (RSTREQ !== 1'b1) begin n_fail++; $display("FAIL lockup_rise got=%b exp=1", RSTREQ); end
    n_checks++;
    if (RST_INFO[RI_LOCKUP] !== 1'b1) begin n_fail++; $display("FAIL lockup_info got=%b exp=xx1x", RST_INFO); end
    ack_and_release(blen, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL lockup_complete got=stuck exp=idle"); end
    LOCKUP_RST_EN = 1'b0;
  endtask

  task automatic test_timeout();
    int len, blen;
    bit ok;
    clear_info();
    exp_q.push_back(32'(MIN_PULSE + ACK_TIMEOUT));
    WDOG_RST = 1'b1;
    tick();
    WDOG_RST = 1'b0;
    len = (RSTREQ === 1'b1) ? 1 : 0;
    count_high(len, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || len !== int'(exp)) begin n_fail++; $display("FAIL timeout_len got=%0d exp=%0d", len, exp); end
    n_checks++;
    if (RST_TIMEOUT !== 1'b1) begin n_fail++; $display("FAIL timeout_flag got=%b exp=1", RST_TIMEOUT); end
    n_checks++;
    if (RST_INFO !== 4'b0100) begin n_fail++; $display("FAIL timeout_info got=%b exp=0100", RST_INFO); end
    count_busy(blen, ok);
    n_checks++;
    if (!ok || blen !== HOLDOFF - 1) begin n_fail++; $display("FAIL timeout_holdoff got=%0d exp=%0d", blen, HOLDOFF - 1); end
  endtask

  task automatic test_multi_cause();
    int blen;
    bit ok, in_hold;
    clear_info();
    exp_q.push_back(32'b1001);
    EXT_RST_REQ = 1'b1;
    tick();
    EXT_RST_REQ = 1'b0;
    tick();
    SYSRESETREQ = 1'b1;
    tick();
    SYSRESETREQ = 1'b0;
    HRESETn_MON = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    HRESETn_MON = 1'b1;
    in_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dbg_state === ST_HOLDOFF) begin in_hold = 1'b1; break; end
    end
    n_checks++;
    if (!in_hold) begin n_fail++; $display("FAIL multi_holdoff got=%0d exp=%0d", dbg_state, ST_HOLDOFF); end
    WDOG_RST = 1'b1;
    tick();
    WDOG_RST = 1'b0;
    count_busy(blen, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (RST_INFO !== exp[3:0]) begin n_fail++; $display("FAIL multi_info got=%b exp=%b", RST_INFO, exp[3:0]); end
    repeat (3) tick();
    n_checks++;
    if (!ok || RSTREQ !== 1'b0 || RST_BUSY !== 1'b0) begin
      n_fail++; $display("FAIL multi_no_retrigger rstreq=%b busy=%b exp=0,0", RSTREQ, RST_BUSY);
    end
  endtask

  task automatic test_clear_collision();
    int len, blen;
    bit ok;
    clear_info();
    LOCKUP_RST_EN = 1'b1;
    {SYSRESETREQ, LOCKUP, WDOG_RST, EXT_RST_REQ} = 4'b1111;
    tick();
    {SYSRESETREQ, LOCKUP, WDOG_RST, EXT_RST_REQ} = 4'b0000;
    LOCKUP_RST_EN = 1'b0;
    len = 1;
    count_high(len, ok);
    n_checks++;
    if (RST_INFO !== 4'b1111 || RST_TIMEOUT !== 1'b1) begin
      n_fail++; $display("FAIL clr_setup info=%b timeout=%b exp=1111,1", RST_INFO, RST_TIMEOUT);
    end
    count_busy(blen, ok);
    exp_q.push_back(32'b0100);
    RST_INFO_CLR = 1'b1;
    WDOG_RST = 1'b1;
    tick();
    RST_INFO_CLR = 1'b0;
    WDOG_RST = 1'b0;
    exp = exp_q.pop_front();
    n_checks++;
    if (RST_INFO !== exp[3:0]) begin n_fail++; $display("FAIL clr_info got=%b exp=%b", RST_INFO, exp[3:0]); end
    n_checks++;
    if (RST_TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL clr_timeout got=%b exp=0", RST_TIMEOUT); end
    n_checks++;
    if (RSTREQ !== 1'b1) begin n_fail++; $display("FAIL clr_new_req got=%b exp=1", RSTREQ); end
    ack_and_release(blen, ok);
  endtask

  task automatic test_poreset_abort();
    int lat, blen;
    bit ok;
    clear_info();
    SYSRESETREQ = 1'b1;
    tick();
    SYSRESETREQ = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (dbg_state !== ST_WAIT_ACK) begin n_fail++; $display("FAIL por_setup got=%0d exp=%0d", dbg_state, ST_WAIT_ACK); end
    #2 PORESET = 1'b1;
    #1;
    n_checks++;
    if (RSTREQ !== 1'b0 || RST_INFO !== 4'b0000 || RST_BUSY !== 1'b0) begin
      n_fail++; $display("FAIL por_async rstreq=%b info=%b busy=%b exp=0,0000,0", RSTREQ, RST_INFO, RST_BUSY);
    end
    tick();
    exp_q.push_back(32'd3);
    PORESET = 1'b0;
    SYSRESETREQ = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (RSTREQ === 1'b1) break;
    end
    SYSRESETREQ = 1'b0;
    exp = exp_q.pop_front();
    n_checks++;
    if (lat !== int'(exp) || RSTREQ !== 1'b1) begin n_fail++; $display("FAIL por_restart_lat got=%0d exp=%0d", lat, exp); end
    ack_and_release(blen, ok);
    n_checks++;
    if (!ok || RST_INFO !== 4'b0001) begin n_fail++; $display("FAIL por_restart_info got=%b exp=0001", RST_INFO); end
  endtask

  initial begin
    test_reset();
    test_sysreq(2, "sysreq_early");
    test_sysreq(5, "sysreq_late");
    test_lockup_enable();
    test_timeout();
    test_multi_cause();
    test_clear_collision();
    test_poreset_abort();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
